// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier producing a 2*WIDTH-bit product as HI/LO words.
// Signed operands are reduced to magnitudes up front; the sign is reapplied at completion.
module mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [W-1:0]   acc_hi;
    logic           neg;
    logic [CW-1:0]  count;

    logic [W:0]     add_op;
    logic [W:0]     sum;
    logic [PW-1:0]  prod;
    logic [PW-1:0]  prod_final;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;

    // One iteration of the datapath plus operand magnitude conversion
    always_comb begin
        add_op     = mplier[0] ? {1'b0, mcand} : '0;
        sum        = {1'b0, acc_hi} + add_op;
        prod       = {sum, mplier[W-1:1]};
        prod_final = neg ? PW'(-prod) : prod;
        mag_a      = (is_signed && multiplicand[W-1]) ? W'(-multiplicand) : multiplicand;
        mag_b      = (is_signed && multiplier[W-1])   ? W'(-multiplier)   : multiplier;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc_hi <= '0;
            neg    <= 1'b0;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        acc_hi <= '0;
                        neg    <= is_signed & (multiplicand[W-1] ^ multiplier[W-1]);
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Shift {carry, acc_hi, multiplier} right; multiplier becomes low accumulator
                    acc_hi <= sum[W:1];
                    mplier <= {sum[0], mplier[W-1:1]};
                    count  <= count + CW'(1);
                    if (count == CW'(W - 1)) begin
                        hi    <= prod_final[PW-1:W];
                        lo    <= prod_final[W-1:0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter: vector table plus hand-written multi-cycle sequences.
module tb_mul_iter;

    logic        clock;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    mul_iter #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .is_signed(is_signed),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation at the next edge and wait for done; returns edges from accept to done
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat);
        @(negedge clock);
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int d0;
        int d1;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;

        vecs[0] = '{"u3x5",        32'd3,          32'd5,          1'b0, 32'h0,        32'hF};
        vecs[1] = '{"u_max_sq",    32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{"s_m1_sq",     32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'h0,        32'h1};
        vecs[3] = '{"s_m7x3",      32'hFFFFFFF9,   32'd3,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[4] = '{"s_min_sq",    32'h80000000,   32'h80000000,   1'b1, 32'h40000000, 32'h0};
        vecs[5] = '{"s_min_x1",    32'h80000000,   32'd1,          1'b1, 32'hFFFFFFFF, 32'h80000000};
        vecs[6] = '{"u_max_x1",    32'hFFFFFFFF,   32'd1,          1'b0, 32'h0,        32'hFFFFFFFF};
        vecs[7] = '{"s_5xm1",      32'd5,          32'hFFFFFFFF,   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB};
        vecs[8] = '{"s_0xm5",      32'd0,          32'hFFFFFFFB,   1'b1, 32'h0,        32'h0};
        vecs[9] = '{"u_6x7",       32'd6,          32'd7,          1'b0, 32'h0,        32'd42};

        reset = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Table: latency, one-cycle done, busy low after completion, product
        for (int k = 0; k < 10; k++) begin
            run_op(vecs[k].a, vecs[k].b, vecs[k].s, lat);
            check({vecs[k].name, "_latency"}, 64'(lat), 64'd32);
            check({vecs[k].name, "_busy_at_done"}, 64'(busy), 64'd0);
            check({vecs[k].name, "_prod"}, {hi, lo}, {vecs[k].exp_hi, vecs[k].exp_lo});
            @(posedge clock);
            #1;
            check({vecs[k].name, "_done_pulse"}, 64'(done), 64'd0);
        end
        prev_hi = vecs[9].exp_hi;
        prev_lo = vecs[9].exp_lo;

        // Start while busy is ignored; hi/lo hold the previous product during the run
        @(negedge clock);
        multiplicand = 32'd6;
        multiplier   = 32'd7;
        is_signed    = 1'b0;
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("ign_busy_rise", 64'(busy), 64'd1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 10) begin
                @(negedge clock);
                multiplicand = 32'd2;
                multiplier   = 32'd2;
                is_signed    = 1'b1;
                start        = 1'b1;
            end
            @(posedge clock);
            #1;
            if (i == 10) start = 1'b0;
            if (i == 20) check("ign_hold_hilo", {hi, lo}, {prev_hi, prev_lo});
            if (done) begin
                lat = i;
                break;
            end
        end
        check("ign_latency", 64'(lat), 64'd32);
        check("ign_prod", {hi, lo}, 64'd42);
        @(posedge clock);
        #1;
        check("ign_no_restart", 64'(busy), 64'd0);

        // Asynchronous reset mid-operation abandons it
        @(negedge clock);
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        is_signed    = 1'b0;
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 15; i++) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        check("rst_no_done", 64'(ndone), 64'd0);
        run_op(32'd2, 32'd3, 1'b0, lat);
        check("rst_after_latency", 64'(lat), 64'd32);
        check("rst_after_prod", {hi, lo}, 64'd6);

        // Start held high: restarts on every idle edge, one product per 33 cycles
        @(negedge clock);
        multiplicand = 32'd1;
        multiplier   = 32'd1;
        is_signed    = 1'b0;
        start        = 1'b1;
        ndone = 0;
        d0 = -1;
        d1 = -1;
        for (int e = 0; e < 70; e++) begin
            @(posedge clock);
            #1;
            if (done) begin
                if (ndone == 0) d0 = e + 1;
                else if (ndone == 1) d1 = e + 1;
                ndone++;
            end
        end
        start = 1'b0;
        check("held_count", 64'(ndone), 64'd2);
        check("held_done_cycle0", 64'(d0), 64'd33);
        check("held_done_cycle1", 64'(d1), 64'd66);
        check("held_prod", {hi, lo}, 64'd1);
        for (int i = 0; i < 40; i++) @(posedge clock);
        #1;
        check("held_drained", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
